// File: rtl/slm_bank_param_init.sv
// slm_bank_param_init: parametrised 1W:1R SLM bank with vertical banks, masked byte lanes, zero-init and write-first forwarding
module slm_bank_param_init #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 17,
  parameter int BANK_ADDR_WIDTH = 11,
  parameter int LANE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE0,
  input  logic [ADDR_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] D0,
  input  logic                  WE0,
  input  logic [DATA_WIDTH-1:0] WEM0,
  input  logic                  CE1,
  input  logic [ADDR_WIDTH-1:0] A1,
  output logic [DATA_WIDTH-1:0] Q1,
  output logic                  Q1_VALID,
  output logic                  READY
);
  localparam int NV = 2 ** (ADDR_WIDTH - BANK_ADDR_WIDTH);
  localparam int NL = (DATA_WIDTH + LANE_WIDTH - 1) / LANE_WIDTH;
  localparam int DWP = NL * LANE_WIDTH;
  localparam int VWS = ADDR_WIDTH > BANK_ADDR_WIDTH ? ADDR_WIDTH - BANK_ADDR_WIDTH : 1;
  localparam int DEPTH = 2 ** BANK_ADDR_WIDTH;
  if (ADDR_WIDTH < BANK_ADDR_WIDTH || DATA_WIDTH < 1) begin : g_bad_cfg
    $error("slm_bank_param_init: illegal configuration");
  end
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [BANK_ADDR_WIDTH-1:0] cnt;
  logic run, seen;
  logic [VWS-1:0] vb0, vb1, sel;
  logic [BANK_ADDR_WIDTH-1:0] row0, row1;
  logic [DWP-1:0] d_p, wem_p, init_p;
  logic [DWP-1:0] rd [NV];
  logic [DATA_WIDTH-1:0] fwd_d, fwd_m;
  assign run = state == RUN;
  assign vb0 = VWS'(A0 >> BANK_ADDR_WIDTH);
  assign vb1 = VWS'(A1 >> BANK_ADDR_WIDTH);
  assign row0 = A0[BANK_ADDR_WIDTH-1:0];
  assign row1 = A1[BANK_ADDR_WIDTH-1:0];
  assign d_p = DWP'(D0);
  assign wem_p = DWP'(WEM0);
  assign init_p = DWP'(INIT_VALUE);
  for (genvar v = 0; v < NV; v++) begin : g_v
    for (genvar l = 0; l < NL; l++) begin : g_l
      logic [LANE_WIDTH-1:0] mem [DEPTH];
      logic [LANE_WIDTH-1:0] q, m, d;
      logic we, re;
      assign m = wem_p[l*LANE_WIDTH +: LANE_WIDTH];
      assign d = d_p[l*LANE_WIDTH +: LANE_WIDTH];
      assign we = run & CE0 & WE0 & (vb0 == VWS'(v)) & (|m);
      assign re = run & CE1 & (vb1 == VWS'(v));
      always_ff @(posedge CLK) begin
        if (!run) mem[cnt] <= init_p[l*LANE_WIDTH +: LANE_WIDTH];
        else if (we) mem[row0] <= (mem[row0] & ~m) | (d & m);
        if (re) q <= mem[row1];
      end
      assign rd[v][l*LANE_WIDTH +: LANE_WIDTH] = q;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= INIT;
      cnt <= '0;
      READY <= 1'b0;
      Q1_VALID <= 1'b0;
      seen <= 1'b0;
      sel <= '0;
      fwd_d <= '0;
      fwd_m <= '0;
    end else begin
      if (!run) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= RUN;
          READY <= 1'b1;
        end
      end
      Q1_VALID <= run & CE1;
      // a same-address write in the read cycle is merged over the bank's old data
      if (run & CE1) begin
        seen <= 1'b1;
        sel <= vb1;
        fwd_d <= D0;
        fwd_m <= (CE0 & WE0 & (A0 == A1)) ? WEM0 : '0;
      end
    end
  end
  assign Q1 = seen ? ((fwd_d & fwd_m) | (rd[sel][DATA_WIDTH-1:0] & ~fwd_m)) : '0;
endmodule
